// File: rtl/my_mux4_pkg.sv
// Shared select encoding for the my_mux4 steering block.
package my_mux4_pkg;

   typedef logic [1:0] sel_t;

   localparam sel_t SEL_A = 2'b00;
   localparam sel_t SEL_B = 2'b01;
   localparam sel_t SEL_C = 2'b10;
   localparam sel_t SEL_D = 2'b11;

endpackage

// File: rtl/mux4_comb.sv
// Purely combinational 4:1 select; zero latency, no flow control.
// An unknown select drives all-X so upstream select faults are visible in simulation.
module mux4_comb
   import my_mux4_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  sel_t             i_sel,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic [WIDTH-1:0] i_c,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_y
);

   always_comb begin
      o_y = 'x;
      case (i_sel)
         SEL_A:   o_y = i_a;
         SEL_B:   o_y = i_b;
         SEL_C:   o_y = i_c;
         SEL_D:   o_y = i_d;
         default: o_y = 'x;
      endcase
   end

endmodule

// File: rtl/my_mux4.sv
// 4:1 mux with combinational tap (y_comb) and registered output (y, sel_q, y_valid), 1-cycle latency.
// No backpressure: in_valid captures every cycle it is high. Optional y_par flop under MY_MUX4_PARITY_EN.
module my_mux4
   import my_mux4_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s0,
   input  logic             s1,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             in_valid,
   output logic [WIDTH-1:0] y_comb,
   output logic [WIDTH-1:0] y,
   output logic             y_valid,
`ifdef MY_MUX4_PARITY_EN
   output logic             y_par,
`endif
   output logic [1:0]       sel_q
);

   sel_t             w_sel;
   logic [WIDTH-1:0] w_y_comb;
   logic [WIDTH-1:0] r_y;
   sel_t             r_sel;
   logic             r_valid;

   assign w_sel = {s1, s0};

   mux4_comb #(
      .WIDTH (WIDTH)
   ) u_comb (
      .i_sel (w_sel),
      .i_a   (a),
      .i_b   (b),
      .i_c   (c),
      .i_d   (d),
      .o_y   (w_y_comb)
   );

   // Data and select only load on in_valid; the valid flag drops on idle cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_y     <= '0;
         r_sel   <= SEL_A;
         r_valid <= 1'b0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_y   <= w_y_comb;
            r_sel <= w_sel;
         end
      end
   end

`ifdef MY_MUX4_PARITY_EN
   logic r_par;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par <= 1'b0;
      end else if (in_valid) begin
         r_par <= ^w_y_comb;
      end
   end

   assign y_par = r_par;
`endif

   assign y_comb  = w_y_comb;
   assign y       = r_y;
   assign sel_q   = r_sel;
   assign y_valid = r_valid;

endmodule

// File: tb/tb_my_mux4.sv
module tb_my_mux4;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s0, s1, in_valid;
   logic       a1, b1, c1, d1;
   logic       y_comb1, y1, y_valid1;
   logic [1:0] sel_q1;
   logic [3:0] a4, b4, c4, d4;
   logic [3:0] y_comb4, y4;
   logic       y_valid4;
   logic [1:0] sel_q4;
`ifdef MY_MUX4_PARITY_EN
   logic       y_par1, y_par4;
`endif

   int n_chk  = 0;
   int n_pass = 0;

   // {s1, s0, a, b, c, d, expected y_comb}
   logic [6:0] sweep [6] = '{7'b00_1000_1, 7'b11_1010_0, 7'b01_0110_1,
                             7'b10_0100_0, 7'b01_0010_0, 7'b11_0111_1};

   always #5 clk = ~clk;

   my_mux4 #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .s0(s0), .s1(s1),
      .a(a1), .b(b1), .c(c1), .d(d1), .in_valid(in_valid),
      .y_comb(y_comb1), .y(y1), .y_valid(y_valid1),
`ifdef MY_MUX4_PARITY_EN
      .y_par(y_par1),
`endif
      .sel_q(sel_q1)
   );

   my_mux4 #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .s0(s0), .s1(s1),
      .a(a4), .b(b4), .c(c4), .d(d4), .in_valid(in_valid),
      .y_comb(y_comb4), .y(y4), .y_valid(y_valid4),
`ifdef MY_MUX4_PARITY_EN
      .y_par(y_par4),
`endif
      .sel_q(sel_q4)
   );

   // Reference: the four inputs form a table and the select is just an index into it.
   function automatic logic [3:0] pick(input logic [1:0] sel, input logic [3:0] va,
                                       input logic [3:0] vb, input logic [3:0] vc,
                                       input logic [3:0] vd);
      logic [3:0] tbl [4];
      tbl[0] = va; tbl[1] = vb; tbl[2] = vc; tbl[3] = vd;
      return tbl[int'(sel)];
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      next_cycle();
      rst_n = 1'b1; {s1, s0} = 2'b11; d1 = 1'b1; d4 = 4'hF; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      n_chk++; if (y1 !== 1'b1) $display("FAIL preload_y got %h exp 1", y1); else n_pass++;
      n_chk++; if (y_valid1 !== 1'b1) $display("FAIL preload_vld got %h exp 1", y_valid1); else n_pass++;
      #2; rst_n = 1'b0; #1;
      n_chk++; if (y1 !== 1'b0) $display("FAIL rst_y1 got %h exp 0", y1); else n_pass++;
      n_chk++; if (y_valid1 !== 1'b0) $display("FAIL rst_vld1 got %h exp 0", y_valid1); else n_pass++;
      n_chk++; if (sel_q1 !== 2'b00) $display("FAIL rst_sel1 got %h exp 0", sel_q1); else n_pass++;
      n_chk++; if (y4 !== 4'h0) $display("FAIL rst_y4 got %h exp 0", y4); else n_pass++;
      n_chk++; if (y_valid4 !== 1'b0) $display("FAIL rst_vld4 got %h exp 0", y_valid4); else n_pass++;
      n_chk++; if (sel_q4 !== 2'b00) $display("FAIL rst_sel4 got %h exp 0", sel_q4); else n_pass++;
`ifdef MY_MUX4_PARITY_EN
      n_chk++; if (y_par4 !== 1'b0) $display("FAIL rst_par4 got %h exp 0", y_par4); else n_pass++;
`endif
      in_valid = 1'b1;
      next_cycle();
      n_chk++; if (y_valid1 !== 1'b0) $display("FAIL rst_hold_vld got %h exp 0", y_valid1); else n_pass++;
      n_chk++; if (y1 !== 1'b0) $display("FAIL rst_hold_y got %h exp 0", y1); else n_pass++;
      in_valid = 1'b0;
      rst_n = 1'b1;
   endtask

   task automatic test_comb_sweep();
      for (int i = 0; i < 6; i++) begin
         logic [6:0] e;
         e = sweep[i];
         {s1, s0, a1, b1, c1, d1} = e[6:1];
         #1;
         n_chk++;
         if (y_comb1 !== e[0]) $display("FAIL sweep%0d got %h exp %h", i, y_comb1, e[0]);
         else n_pass++;
      end
   endtask

   task automatic test_comb_random();
      for (int i = 0; i < 24; i++) begin
         logic [3:0] exp4;
         {s1, s0} = 2'($urandom_range(0, 3));
         a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom); d4 = 4'($urandom);
         exp4 = pick({s1, s0}, a4, b4, c4, d4);
         #1;
         n_chk++;
         if (y_comb4 !== exp4) $display("FAIL comb_rand%0d got %h exp %h", i, y_comb4, exp4);
         else n_pass++;
      end
   endtask

   task automatic test_registered();
      {s1, s0} = 2'b10; a1 = 1'b0; b1 = 1'b0; c1 = 1'b1; d1 = 1'b0; in_valid = 1'b1;
      next_cycle();
      n_chk++; if (y1 !== 1'b1) $display("FAIL reg_y got %h exp 1", y1); else n_pass++;
      n_chk++; if (sel_q1 !== 2'b10) $display("FAIL reg_sel got %h exp 2", sel_q1); else n_pass++;
      n_chk++; if (y_valid1 !== 1'b1) $display("FAIL reg_vld got %h exp 1", y_valid1); else n_pass++;
      in_valid = 1'b0; c1 = 1'b0;
      next_cycle();
      n_chk++; if (y1 !== 1'b1) $display("FAIL hold_y got %h exp 1", y1); else n_pass++;
      n_chk++; if (y_valid1 !== 1'b0) $display("FAIL hold_vld got %h exp 0", y_valid1); else n_pass++;
      n_chk++; if (sel_q1 !== 2'b10) $display("FAIL hold_sel got %h exp 2", sel_q1); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [3:0] vals;
      vals = 4'b1010;   // a..d = 1,0,1,0 with a in bit 3
      {a1, b1, c1, d1} = vals;
      in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         logic exp1;
         {s1, s0} = 2'(i);
         exp1 = vals[3 - i];
         next_cycle();
         n_chk++; if (y1 !== exp1) $display("FAIL stream_y%0d got %h exp %h", i, y1, exp1); else n_pass++;
         n_chk++; if (y_valid1 !== 1'b1) $display("FAIL stream_vld%0d got %h exp 1", i, y_valid1); else n_pass++;
         n_chk++; if (sel_q1 !== 2'(i)) $display("FAIL stream_sel%0d got %h exp %h", i, sel_q1, 2'(i)); else n_pass++;
      end
      in_valid = 1'b0;
   endtask

   task automatic test_random_stream();
      logic [3:0] m_y;
      logic [1:0] m_sel;
      logic       m_vld;
      m_y = y4; m_sel = sel_q4; m_vld = 1'b0;
      for (int i = 0; i < 40; i++) begin
         {s1, s0} = 2'($urandom_range(0, 3));
         a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom); d4 = 4'($urandom);
         in_valid = ($urandom_range(0, 3) != 0);
         if (in_valid) begin
            m_y = pick({s1, s0}, a4, b4, c4, d4);
            m_sel = {s1, s0};
         end
         m_vld = in_valid;
         next_cycle();
         n_chk++; if (y4 !== m_y) $display("FAIL rstream_y%0d got %h exp %h", i, y4, m_y); else n_pass++;
         n_chk++; if (y_valid4 !== m_vld) $display("FAIL rstream_vld%0d got %h exp %h", i, y_valid4, m_vld); else n_pass++;
         n_chk++; if (sel_q4 !== m_sel) $display("FAIL rstream_sel%0d got %h exp %h", i, sel_q4, m_sel); else n_pass++;
`ifdef MY_MUX4_PARITY_EN
         n_chk++; if (y_par4 !== ^m_y) $display("FAIL rstream_par%0d got %h exp %h", i, y_par4, ^m_y); else n_pass++;
`endif
      end
      in_valid = 1'b0;
   endtask

   task automatic test_reset_midstream();
      {s1, s0} = 2'b01; a1 = 1'b0; b1 = 1'b1; c1 = 1'b0; d1 = 1'b0; in_valid = 1'b1;
      next_cycle();
      n_chk++; if (y1 !== 1'b1) $display("FAIL mid_pre_y got %h exp 1", y1); else n_pass++;
      {s1, s0} = 2'b10; c1 = 1'b1;
      #3; rst_n = 1'b0; #1;
      n_chk++; if (y1 !== 1'b0) $display("FAIL mid_rst_y got %h exp 0", y1); else n_pass++;
      n_chk++; if (y_valid1 !== 1'b0) $display("FAIL mid_rst_vld got %h exp 0", y_valid1); else n_pass++;
      next_cycle();
      n_chk++; if (y_valid1 !== 1'b0) $display("FAIL mid_discard_vld got %h exp 0", y_valid1); else n_pass++;
      rst_n = 1'b1;
      #1;
      n_chk++; if (y_valid1 !== 1'b0) $display("FAIL mid_release_vld got %h exp 0", y_valid1); else n_pass++;
      next_cycle();
      n_chk++; if (y_valid1 !== 1'b1) $display("FAIL mid_first_vld got %h exp 1", y_valid1); else n_pass++;
      n_chk++; if (y1 !== 1'b1) $display("FAIL mid_first_y got %h exp 1", y1); else n_pass++;
      n_chk++; if (sel_q1 !== 2'b10) $display("FAIL mid_first_sel got %h exp 2", sel_q1); else n_pass++;
      in_valid = 1'b0;
   endtask

`ifdef MY_MUX4_PARITY_EN
   task automatic test_parity();
      d4 = 4'b0111; {s1, s0} = 2'b11; in_valid = 1'b1;
      next_cycle();
      in_valid = 1'b0;
      n_chk++; if (y4 !== 4'b0111) $display("FAIL par_y got %h exp 7", y4); else n_pass++;
      n_chk++; if (y_par4 !== 1'b1) $display("FAIL par_bit got %h exp 1", y_par4); else n_pass++;
      d4 = 4'b0110;
      next_cycle();
      n_chk++; if (y_par4 !== 1'b1) $display("FAIL par_hold got %h exp 1", y_par4); else n_pass++;
   endtask
`endif

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; s0 = 1'b0; s1 = 1'b0;
      a1 = 1'b0; b1 = 1'b0; c1 = 1'b0; d1 = 1'b0;
      a4 = 4'h0; b4 = 4'h0; c4 = 4'h0; d4 = 4'h0;
      test_reset();
      test_comb_sweep();
      test_comb_random();
      test_registered();
      test_back_to_back();
      test_random_stream();
      test_reset_midstream();
`ifdef MY_MUX4_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
